// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, store-size codes and span helpers for the data memory controller
package mem_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ_LO, S_READ_HI, S_WRITE_LO, S_WRITE_HI, S_DONE} state_t;
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_WORD = 2'd3;
  // MEM_NONE maps to 4 because a pure load always touches a full 32-bit window
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == MEM_BYTE ? 3'd1 : size == MEM_HALF ? 3'd2 : 3'd4;
  endfunction
  function automatic logic spans_words(input logic [1:0] offset, input logic [2:0] n);
    return ({1'b0, offset} + n) > 3'd4;
  endfunction
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: splices store bytes into a two-word window and extracts the unaligned load window
//   window     in  64  {hi, lo} words as read from SRAM
//   offset     in  2   byte offset of the access inside lo
//   n          in  3   number of store bytes (1, 2 or 4)
//   store_data in  32  store bytes, taken from the LSB upward
//   merged     out 64  window with bytes offset..offset+n-1 replaced
//   load_data  out 32  little-endian 32-bit view starting at offset
module byte_lane_merge (
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  n,
  input  logic [31:0] store_data,
  output logic [63:0] merged,
  output logic [31:0] load_data
);
  always_comb begin
    merged = window;
    for (int i = 0; i < 4; i++)
      if (i < int'(n)) merged[8*(int'(offset)+i) +: 8] = store_data[8*i +: 8];
  end
  assign load_data = 32'(window >> {offset, 3'b000});
endmodule

// File: rtl/data_memory_controller.sv
// data_memory_controller: byte/half/word load-store engine over a word-wide SRAM without byte enables
//   clk, rst (sync, active-low)
//   memory_address/memory_data_store/memory_read/memory_write  request from the memory-access stage
//   memory_data_load/memory_wait/misaligned_fault               response to the pipeline
//   sram_addr/sram_re/sram_we/sram_wdata/sram_rdata             single-ported synchronous SRAM
// Build option MISALIGNED_SPLIT_EN: word-crossing accesses become two word transactions;
// without it such requests complete in DONE with a misaligned_fault pulse and no SRAM traffic.
module data_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       memory_address,
  input  logic [31:0]       memory_data_store,
  input  logic              memory_read,
  input  logic [1:0]        memory_write,
  output logic [31:0]       memory_data_load,
  output logic              memory_wait,
  output logic              misaligned_fault,
  output logic [ADDR_W-3:0] sram_addr,
  output logic              sram_re,
  output logic              sram_we,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int AW = ADDR_W - 2;
  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [1:0]      off_q;
  logic [2:0]      n_q, n_in;
  logic [31:0]     data_q, lo, hi, load_data;
  logic            wr_q, span_q, fault_q;
  logic            req, skip_rd, span_in, hi_phase;
  logic [63:0]     window, merged;
  logic            unused_addr;
  assign unused_addr = ^memory_address[31:ADDR_W];
  assign req         = memory_read | (memory_write != MEM_NONE);
  assign n_in        = size_bytes(memory_write);
  assign span_in     = spans_words(memory_address[1:0], n_in);
  assign skip_rd     = memory_write == MEM_WORD && memory_address[1:0] == 2'd0;
  assign memory_wait = req && state != S_DONE;
  // The first read is issued combinationally from IDLE so its data lands in READ_LO;
  // every strobe is gated by rst so a reset cycle never touches the SRAM.
  assign sram_re = rst && ((state == S_IDLE && req && !skip_rd && (SPLIT || !span_in)) ||
                           (state == S_READ_LO && span_q));
  assign sram_we = rst && (state == S_WRITE_LO || state == S_WRITE_HI);
  assign hi_phase = state == S_READ_LO || state == S_WRITE_HI;
  // addr_q + 1 wraps naturally at AW bits, so the last word is followed by word 0
  assign sram_addr = !(sram_re || sram_we) ? '0 :
                     state == S_IDLE ? memory_address[ADDR_W-1:2] :
                     hi_phase ? addr_q + AW'(1) : addr_q;
  assign sram_wdata = !sram_we ? '0 : state == S_WRITE_HI ? merged[63:32] : merged[31:0];
  // Bypass sram_rdata while it is being captured so the load result can be registered on entry to DONE
  assign window = {(state == S_READ_HI) ? sram_rdata : (span_q ? hi : 32'd0),
                   (state == S_READ_LO) ? sram_rdata : lo};
  assign misaligned_fault = !SPLIT && fault_q;
  byte_lane_merge u_merge (
    .window     (window),
    .offset     (off_q),
    .n          (n_q),
    .store_data (data_q),
    .merged     (merged),
    .load_data  (load_data)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state            <= S_IDLE;
      memory_data_load <= '0;
      fault_q          <= 1'b0;
      addr_q           <= '0;
      off_q            <= '0;
      n_q              <= '0;
      data_q           <= '0;
      wr_q             <= 1'b0;
      span_q           <= 1'b0;
      lo               <= '0;
      hi               <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          addr_q <= memory_address[ADDR_W-1:2];
          off_q  <= memory_address[1:0];
          n_q    <= n_in;
          data_q <= memory_data_store;
          wr_q   <= memory_write != MEM_NONE;
          span_q <= span_in;
          lo     <= '0;
          hi     <= '0;
          if (span_in && !SPLIT) begin
            state            <= S_DONE;
            fault_q          <= 1'b1;
            memory_data_load <= '0;
          end else state <= skip_rd ? S_WRITE_LO : S_READ_LO;
        end
        S_READ_LO: begin
          lo    <= sram_rdata;
          state <= span_q ? S_READ_HI : wr_q ? S_WRITE_LO : S_DONE;
          if (!span_q && !wr_q) memory_data_load <= load_data;
        end
        S_READ_HI: begin
          hi    <= sram_rdata;
          state <= wr_q ? S_WRITE_LO : S_DONE;
          if (!wr_q) memory_data_load <= load_data;
        end
        S_WRITE_LO: begin
          state <= span_q ? S_WRITE_HI : S_DONE;
          if (!span_q) memory_data_load <= load_data;
        end
        S_WRITE_HI: begin
          state            <= S_DONE;
          memory_data_load <= load_data;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_memory_controller.sv
// tb_data_memory_controller: table-driven scoreboard bench for data_memory_controller
module tb_data_memory_controller;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [1:0]  wr;
    logic        chk_ld;
    logic [31:0] ld;
    int          cyc;
    logic        flt;
    int          we;
    int          w0;
    logic [31:0] m0;
    int          w1;
    logic [31:0] m1;
  } vec_t;

  logic        clk, rst;
  logic [31:0] memory_address, memory_data_store, memory_data_load, sram_wdata, sram_rdata;
  logic        memory_read, memory_wait, misaligned_fault, sram_re, sram_we;
  logic [1:0]  memory_write;
  logic [13:0] sram_addr;
  logic [31:0] mem [0:16383];
  int          re_cnt, we_cnt, both_cnt, pass_cnt, total_cnt;
  logic [13:0] last_re;
  vec_t        v [10];
  vec_t        sb [$];

  data_memory_controller #(.ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .memory_address    (memory_address),
    .memory_data_store (memory_data_store),
    .memory_read       (memory_read),
    .memory_write      (memory_write),
    .memory_data_load  (memory_data_load),
    .memory_wait       (memory_wait),
    .misaligned_fault  (misaligned_fault),
    .sram_addr         (sram_addr),
    .sram_re           (sram_re),
    .sram_we           (sram_we),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_re) begin
      sram_rdata <= mem[sram_addr];
      last_re = sram_addr;
      re_cnt++;
    end
    if (sram_we) begin
      mem[sram_addr] = sram_wdata;
      we_cnt++;
    end
    if (sram_re && sram_we) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic rd,
                              input logic [1:0] wr, input logic chk_ld, input logic [31:0] ld,
                              input int cyc, input logic flt, input int we, input int w0,
                              input logic [31:0] m0, input int w1, input logic [31:0] m1);
    vec_t r;
    r.addr = a; r.data = d; r.rd = rd; r.wr = wr; r.chk_ld = chk_ld; r.ld = ld;
    r.cyc = cyc; r.flt = flt; r.we = we; r.w0 = w0; r.m0 = m0; r.w1 = w1; r.m1 = m1;
    return r;
  endfunction

  task automatic run_vec(input vec_t t, input string tag);
    vec_t e;
    int   cyc, we0;
    bit   done;
    logic [31:0] ld;
    logic flt;
    @(posedge clk); #1;
    memory_address = t.addr; memory_data_store = t.data;
    memory_read = t.rd; memory_write = t.wr;
    sb.push_back(t);
    we0 = we_cnt; cyc = 0; done = 0; ld = '0; flt = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (!memory_wait) begin
        done = 1; ld = memory_data_load; flt = misaligned_fault;
      end
    end
    @(posedge clk); #1;
    memory_read = 1'b0; memory_write = 2'd0;
    if (!done) begin
      total_cnt++;
      $display("FAIL %s_timeout: got no completion expected completion in 20 cycles", tag);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_cycles"}, cyc, e.cyc);
      chk({tag, "_fault"}, flt, e.flt);
      if (e.chk_ld) chk({tag, "_load"}, ld, e.ld);
      chk({tag, "_we_count"}, we_cnt - we0, e.we);
      chk({tag, "_mem_lo"}, mem[e.w0], e.m0);
      chk({tag, "_mem_hi"}, mem[e.w1], e.m1);
    end
  endtask

  initial begin
    int r0, w0;
    pass_cnt = 0; total_cnt = 0; re_cnt = 0; we_cnt = 0; both_cnt = 0; last_re = '0;
    rst = 1'b0; memory_address = '0; memory_data_store = '0; memory_read = 1'b0; memory_write = 2'd0;
    mem['h10] = 32'hDDCCBBAA; mem['h11] = 32'h55667788;
    mem['h20] = 32'h11223344; mem['h21] = 32'h99999999;
    mem['h24] = 32'h00000000; mem['h25] = 32'h77777777;
    mem['h28] = 32'hAABBCCDD; mem['h29] = 32'h0BADF00D;
    mem['h2C] = 32'h01020304; mem['h2D] = 32'h5A5A5A5A;
    mem['h30] = 32'h11111111; mem['h31] = 32'h22222222;
    mem['h34] = 32'h33333333; mem['h35] = 32'h44444444;
    mem['h38] = 32'h00000000; mem['h39] = 32'h13572468;
    mem['h3FFF] = 32'h44332211; mem[0] = 32'h88776655;
    v[0] = mk(32'h40, 0, 1, 0, 1, 32'hDDCCBBAA, 3, 0, 0, 'h10, 32'hDDCCBBAA, 'h11, 32'h55667788);
    v[1] = mk(32'h41, 0, 1, 0, 1, SPLIT ? 32'h88DDCCBB : 32'h0, SPLIT ? 4 : 2, !SPLIT, 0,
              'h10, 32'hDDCCBBAA, 'h11, 32'h55667788);
    v[2] = mk(32'h82, 32'hEE, 0, 1, 0, 0, 4, 0, 1, 'h20, 32'h11EE3344, 'h21, 32'h99999999);
    v[3] = mk(32'h90, 32'hCAFEBABE, 0, 3, 0, 0, 3, 0, 1, 'h24, 32'hCAFEBABE, 'h25, 32'h77777777);
    v[4] = mk(32'hA1, 32'hFFFF1234, 0, 2, 0, 0, 4, 0, 1, 'h28, 32'hAA1234DD, 'h29, 32'h0BADF00D);
    v[5] = mk(32'hC3, 32'hAABBCCDD, 0, 3, !SPLIT, 0, SPLIT ? 6 : 2, !SPLIT, SPLIT ? 2 : 0,
              'h30, SPLIT ? 32'hDD111111 : 32'h11111111, 'h31, SPLIT ? 32'h22AABBCC : 32'h22222222);
    v[6] = mk(32'hB2, 32'h0000BEEF, 1, 2, 1, 32'h00000102, 4, 0, 1,
              'h2C, 32'hBEEF0304, 'h2D, 32'h5A5A5A5A);
    v[7] = mk(32'hD3, 32'h5566, 0, 2, !SPLIT, 0, SPLIT ? 6 : 2, !SPLIT, SPLIT ? 2 : 0,
              'h34, SPLIT ? 32'h66333333 : 32'h33333333, 'h35, SPLIT ? 32'h44444455 : 32'h44444444);
    v[8] = mk(32'hE3, 32'h7F, 0, 1, 0, 0, 4, 0, 1, 'h38, 32'h7F000000, 'h39, 32'h13572468);
    v[9] = mk(32'h1234FFFE, 0, 1, 0, 1, SPLIT ? 32'h66554433 : 32'h0, SPLIT ? 4 : 2, !SPLIT, 0,
              'h3FFF, 32'h44332211, 0, 32'h88776655);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_load", memory_data_load, 0);
    chk("reset_fault", misaligned_fault, 0);
    chk("reset_re", sram_re, 0);
    chk("reset_we", sram_we, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_wdata", sram_wdata, 0);
    chk("reset_wait", memory_wait, 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(v[i], $sformatf("vec%0d", i));

    last_re = 14'h1555;
    r0 = re_cnt;
    run_vec(v[9], "wrap");
    chk("wrap_last_read_addr", last_re, SPLIT ? 32'h0 : 32'h1555);
    chk("wrap_read_count", re_cnt - r0, SPLIT ? 2 : 0);

    run_vec(v[0], "pre_reset");
    @(posedge clk); #1;
    memory_address = SPLIT ? 32'h41 : 32'h40; memory_read = 1'b1;
    repeat (SPLIT ? 2 : 1) @(posedge clk);
    #1 rst = 1'b0; memory_read = 1'b0;
    @(negedge clk);
    chk("midrst_re", sram_re, 0);
    chk("midrst_we", sram_we, 0);
    r0 = re_cnt; w0 = we_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_wait", memory_wait, 0);
    chk("midrst_load_cleared", memory_data_load, 0);
    repeat (3) @(posedge clk);
    chk("midrst_no_strobes", (re_cnt - r0) + (we_cnt - w0), 0);
    run_vec(v[0], "post_reset");

    chk("single_strobe", both_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
